// File: rtl/wb_ram_bist_if.sv
`default_nettype none
// ============================================================================
// Module : wb_ram_bist_if
// Classic Wishbone bus between the RAM self-test master and the SRAM slave.
// Rev    : 1.0
// ============================================================================
interface wb_ram_bist_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      wbm_cyc_o;
  logic                      wbm_stb_o;
  logic                      wbm_we_o;
  logic [DATA_WIDTH/8-1:0]   wbm_sel_o;
  logic [31:0]               wbm_adr_o;
  logic [DATA_WIDTH-1:0]     wbm_dat_o;
  logic [DATA_WIDTH-1:0]     wbm_dat_i;
  logic                      wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/wb_ram_bist.sv
`default_nettype none
// ============================================================================
// Module : wb_ram_bist
// Wishbone-master SRAM self-test: pattern write/readback, mismatch and timeout report.
// Rev    : 1.0
// ============================================================================
module wb_ram_bist #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          TIMEOUT    = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic                  invert_i,
  input  logic [ADDR_WIDTH:0]   words_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  wb_ram_bist_if.master         wbm,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [5:0]            checkpoint_o,
  output logic [1:0]            status_o,
  output logic [15:0]           err_count_o,
  output logic [31:0]           err_addr_o,
  output logic [DATA_WIDTH-1:0] err_data_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [5:0]            c_cp_run    = 6'b101010;
  localparam logic [5:0]            c_cp_done   = 6'b101011;
  localparam logic [1:0]            c_st_pass   = 2'b00;
  localparam logic [1:0]            c_st_miss   = 2'b01;
  localparam logic [1:0]            c_st_tmo    = 2'b10;
  localparam logic [15:0]           c_tmo_load  = 16'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0]   c_idx_one   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] c_lfsr_one  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  // Maximal-length Galois taps for the common widths; a plain top-bit feedback otherwise.
  localparam logic [63:0]           c_taps_wide = (DATA_WIDTH == 64) ? 64'hD800_0000_0000_0000 :
                                                  (DATA_WIDTH == 32) ? 64'h0000_0000_8020_0003 :
                                                  (DATA_WIDTH == 16) ? 64'h0000_0000_0000_B400 :
                                                                       64'h0000_0000_0000_00B8;
  localparam logic [DATA_WIDTH-1:0] c_lfsr_taps = (DATA_WIDTH <= 64) ? DATA_WIDTH'(c_taps_wide) :
                                                  {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                  r_state;
  logic [1:0]              r_mode;
  logic                    r_invert;
  logic [ADDR_WIDTH:0]     r_words;
  logic [ADDR_WIDTH:0]     r_idx;
  logic [DATA_WIDTH-1:0]   r_seed;
  logic [DATA_WIDTH-1:0]   r_lfsr;
  logic                    r_pass;
  logic [15:0]             r_tmo;
  logic                    r_cyc;
  logic                    r_stb;
  logic                    r_we;
  logic [DATA_WIDTH/8-1:0] r_sel;
  logic [31:0]             r_adr;
  logic [DATA_WIDTH-1:0]   r_dat_o;
  logic                    r_busy;
  logic                    r_done;
  logic [5:0]              r_checkpoint;
  logic [1:0]              r_status;
  logic [15:0]             r_err_count;
  logic [31:0]             r_err_addr;
  logic [DATA_WIDTH-1:0]   r_err_data;

  logic [DATA_WIDTH-1:0]   w_base;
  logic [DATA_WIDTH-1:0]   w_pattern;
  logic [DATA_WIDTH-1:0]   w_lfsr_next;
  logic [DATA_WIDTH-1:0]   w_lfsr_reload;
  logic [31:0]             w_adr;
  logic                    w_last;
  logic                    w_ack;
  logic                    w_mismatch;
  logic [15:0]             w_err_next;

  always_comb begin
    w_base = r_seed;
    case (r_mode)
      2'd0: w_base = DATA_WIDTH'(r_idx);
      2'd1: w_base = r_idx[0] ? {(DATA_WIDTH/8){8'hAA}} : {(DATA_WIDTH/8){8'h55}};
      2'd2: w_base = r_seed;
      2'd3: w_base = r_lfsr;
    endcase
  end

  assign w_pattern     = w_base ^ {DATA_WIDTH{r_pass}};
  assign w_lfsr_next   = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_lfsr_taps : '0);
  assign w_lfsr_reload = (r_seed == '0) ? c_lfsr_one : r_seed;
  assign w_adr         = BASE_ADDR + (32'(r_idx) << 2);
  assign w_last        = (r_idx + c_idx_one) == r_words;
  // Acks outside an active strobe never advance the engine.
  assign w_ack         = wbm.wbm_ack_i & r_stb;
  assign w_mismatch    = wbm.wbm_dat_i != w_pattern;
  assign w_err_next    = (w_mismatch && (r_err_count != 16'hFFFF)) ? r_err_count + 16'd1
                                                                  : r_err_count;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= S_IDLE;
      r_mode       <= '0;
      r_invert     <= 1'b0;
      r_words      <= '0;
      r_idx        <= '0;
      r_seed       <= '0;
      r_lfsr       <= '0;
      r_pass       <= 1'b0;
      r_tmo        <= '0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_sel        <= '0;
      r_adr        <= '0;
      r_dat_o      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_checkpoint <= '0;
      r_status     <= '0;
      r_err_count  <= '0;
      r_err_addr   <= '0;
      r_err_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_mode       <= mode_i;
            r_invert     <= invert_i;
            r_words      <= words_i;
            r_seed       <= seed_i;
            r_lfsr       <= (seed_i == '0) ? c_lfsr_one : seed_i;
            r_idx        <= '0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_err_addr   <= '0;
            r_err_data   <= '0;
            r_status     <= c_st_pass;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_checkpoint <= c_cp_run;
            r_state      <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (r_words == '0) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_checkpoint <= c_cp_done;
            r_status     <= c_st_pass;
            r_state      <= S_DONE;
          end else begin
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= 1'b1;
            r_sel   <= '1;
            r_adr   <= w_adr;
            r_dat_o <= w_pattern;
            r_tmo   <= c_tmo_load;
            r_state <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (w_ack) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_sel <= '0;
            if (w_last) begin
              r_idx   <= '0;
              r_lfsr  <= w_lfsr_reload;
              r_state <= S_RD_REQ;
            end else begin
              r_idx   <= r_idx + c_idx_one;
              r_lfsr  <= w_lfsr_next;
              r_state <= S_WR_REQ;
            end
          end else if (r_tmo == 16'd0) begin
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_sel        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_checkpoint <= c_cp_done;
            r_status     <= c_st_tmo;
            r_state      <= S_DONE;
          end else begin
            r_tmo <= r_tmo - 16'd1;
          end
        end
        S_RD_REQ: begin
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_we    <= 1'b0;
          r_sel   <= '1;
          r_adr   <= w_adr;
          r_dat_o <= '0;
          r_tmo   <= c_tmo_load;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (w_ack) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_sel <= '0;
            if (w_mismatch) begin
              r_err_count <= w_err_next;
              if (r_err_count == 16'd0) begin
                r_err_addr <= r_adr;
                r_err_data <= wbm.wbm_dat_i;
              end
            end
            if (!w_last) begin
              r_idx   <= r_idx + c_idx_one;
              r_lfsr  <= w_lfsr_next;
              r_state <= S_RD_REQ;
            end else if (r_invert && !r_pass) begin
              r_pass  <= 1'b1;
              r_idx   <= '0;
              r_lfsr  <= w_lfsr_reload;
              r_state <= S_WR_REQ;
            end else begin
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_checkpoint <= c_cp_done;
              r_status     <= (w_err_next != 16'd0) ? c_st_miss : c_st_pass;
              r_state      <= S_DONE;
            end
          end else if (r_tmo == 16'd0) begin
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_sel        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_checkpoint <= c_cp_done;
            r_status     <= c_st_tmo;
            r_state      <= S_DONE;
          end else begin
            r_tmo <= r_tmo - 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wbm.wbm_cyc_o = r_cyc;
  assign wbm.wbm_stb_o = r_stb;
  assign wbm.wbm_we_o  = r_we;
  assign wbm.wbm_sel_o = r_sel;
  assign wbm.wbm_adr_o = r_adr;
  assign wbm.wbm_dat_o = r_dat_o;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign checkpoint_o  = r_checkpoint;
  assign status_o      = r_status;
  assign err_count_o   = r_err_count;
  assign err_addr_o    = r_err_addr;
  assign err_data_o    = r_err_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_bist.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_ram_bist
// Self-checking bench: 1-cycle-ack SRAM model with fault injection and bus scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_wb_ram_bist;
  localparam int          DW   = 32;
  localparam int          AW   = 10;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic          invert;
  logic [AW:0]   words;
  logic [DW-1:0] seed;
  logic          busy, done;
  logic [5:0]    cp;
  logic [1:0]    status;
  logic [15:0]   err_count;
  logic [31:0]   err_addr;
  logic [DW-1:0] err_data;

  wb_ram_bist_if #(.DATA_WIDTH(DW)) wb ();

  wb_ram_bist #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .TIMEOUT(255)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .mode_i(mode),
    .invert_i(invert), .words_i(words), .seed_i(seed), .wbm(wb),
    .busy_o(busy), .done_o(done), .checkpoint_o(cp), .status_o(status),
    .err_count_o(err_count), .err_addr_o(err_addr), .err_data_o(err_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [31:0]   adr;
    logic [DW-1:0] dat;
  } txn_t;

  typedef struct {
    logic [1:0]    mode;
    logic          invert;
    logic [AW:0]   words;
    logic [DW-1:0] seed;
    logic [1:0]    stuck;     // 0 none, 1 bit 3 stuck high at word 5, 2 at every word
    logic          restart;   // pulse start mid-run with different settings
    logic [1:0]    exp_status;
    logic [15:0]   exp_err;
    logic [31:0]   exp_addr;
    logic [DW-1:0] exp_data;
    int            exp_acks;
  } vec_t;

  txn_t          sb_q[$];
  vec_t          vecs[9];
  int            checks  = 0;
  int            errors  = 0;
  int            ack_cnt = 0;
  logic          ack_en  = 1'b1;
  logic [1:0]    stuck   = 2'd0;
  logic [DW-1:0] mem [0:1023];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM model: answers each new strobe with ack one cycle later and scores the request.
  always @(negedge clk) begin : b_slave
    txn_t          e;
    int            widx;
    logic [DW-1:0] rd;
    if (ack_en && wb.wbm_cyc_o && wb.wbm_stb_o && !wb.wbm_ack_i) begin
      widx = int'(wb.wbm_adr_o[11:2]);
      if (wb.wbm_we_o) mem[widx] = wb.wbm_dat_o;
      rd = mem[widx];
      if (stuck == 2'd2 || (stuck == 2'd1 && widx == 5)) rd = rd | 32'h0000_0008;
      wb.wbm_dat_i = rd;
      wb.wbm_ack_i = 1'b1;
      ack_cnt++;
      check("bus_sel", 64'(wb.wbm_sel_o), 64'hF);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL bus_unexpected_txn: got adr %0h with no transaction expected", wb.wbm_adr_o);
      end else begin
        e = sb_q.pop_front();
        check("bus_we", 64'(wb.wbm_we_o), 64'(e.we));
        check("bus_adr", 64'(wb.wbm_adr_o), 64'(e.adr));
        if (e.we) check("bus_wdat", 64'(wb.wbm_dat_o), 64'(e.dat));
      end
    end else begin
      wb.wbm_ack_i = 1'b0;
    end
  end

  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 32'h8020_0003;
    return y;
  endfunction

  function automatic logic [DW-1:0] model_data(input logic [1:0] m, input int i,
                                               input logic [DW-1:0] s, input logic [DW-1:0] l);
    case (m)
      2'd0:    return DW'(i);
      2'd1:    return (i % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
      2'd2:    return s;
      default: return l;
    endcase
  endfunction

  task automatic push_expected(input logic [1:0] m, input logic inv, input int n,
                               input logic [DW-1:0] s);
    txn_t          t;
    logic [DW-1:0] lf;
    for (int p = 0; p <= int'(inv); p++) begin
      for (int ph = 0; ph < 2; ph++) begin
        lf = (s == '0) ? 32'h1 : s;
        for (int i = 0; i < n; i++) begin
          t.we  = (ph == 0);
          t.adr = BASE + 32'(4 * i);
          t.dat = model_data(m, i, s, lf) ^ ((p == 1) ? 32'hFFFF_FFFF : 32'h0);
          sb_q.push_back(t);
          lf = lfsr_step(lf);
        end
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cyc"}, 64'(wb.wbm_cyc_o), 0);
    check({tag, "_stb"}, 64'(wb.wbm_stb_o), 0);
    check({tag, "_we"}, 64'(wb.wbm_we_o), 0);
    check({tag, "_sel"}, 64'(wb.wbm_sel_o), 0);
    check({tag, "_adr"}, 64'(wb.wbm_adr_o), 0);
    check({tag, "_wdat"}, 64'(wb.wbm_dat_o), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_cp"}, 64'(cp), 0);
    check({tag, "_status"}, 64'(status), 0);
    check({tag, "_errcnt"}, 64'(err_count), 0);
    check({tag, "_erraddr"}, 64'(err_addr), 0);
    check({tag, "_errdata"}, 64'(err_data), 0);
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic inv, input logic [AW:0] n,
                             input logic [DW-1:0] s);
    @(negedge clk);
    mode = m; invert = inv; words = n; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int    cyc_n;
    string tag;
    tag     = $sformatf("v%0d", n);
    stuck   = v.stuck;
    ack_en  = 1'b1;
    ack_cnt = 0;
    sb_q.delete();
    push_expected(v.mode, v.invert, int'(v.words), v.seed);
    pulse_start(v.mode, v.invert, v.words, v.seed);
    check({tag, "_busy_run"}, 64'(busy), 1);
    check({tag, "_cp_run"}, 64'(cp), 64'b101010);
    check({tag, "_done_run"}, 64'(done), 0);
    cyc_n = 0;
    while (!done && cyc_n < 20000) begin
      @(negedge clk);
      cyc_n++;
      if (v.restart && cyc_n == 10) begin
        start = 1'b1; words = 11'd3; mode = 2'd2;
      end
      if (cyc_n == 11) start = 1'b0;
    end
    check({tag, "_done"}, 64'(done), 1);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_cp"}, 64'(cp), 64'b101011);
    check({tag, "_status"}, 64'(status), 64'(v.exp_status));
    check({tag, "_errcnt"}, 64'(err_count), 64'(v.exp_err));
    check({tag, "_erraddr"}, 64'(err_addr), 64'(v.exp_addr));
    check({tag, "_errdata"}, 64'(err_data), 64'(v.exp_data));
    check({tag, "_acks"}, 64'(ack_cnt), 64'(v.exp_acks));
    check({tag, "_sb_left"}, 64'(sb_q.size()), 0);
    stuck = 2'd0;
  endtask

  initial begin : b_main
    int cnt;
    int k;
    vecs[0] = '{2'd0, 1'b0, 11'd16,   32'h0,         2'd0, 1'b0, 2'b00, 16'd0,  32'h0,         32'h0,         32};
    vecs[1] = '{2'd1, 1'b1, 11'd4,    32'h0,         2'd0, 1'b0, 2'b00, 16'd0,  32'h0,         32'h0,         16};
    vecs[2] = '{2'd3, 1'b0, 11'd1024, 32'h0,         2'd0, 1'b0, 2'b00, 16'd0,  32'h0,         32'h0,         2048};
    vecs[3] = '{2'd2, 1'b0, 11'd16,   32'h0,         2'd1, 1'b0, 2'b01, 16'd1,  32'h3000_0014, 32'h0000_0008, 32};
    vecs[4] = '{2'd3, 1'b1, 11'd37,   32'hDEAD_BEEF, 2'd0, 1'b0, 2'b00, 16'd0,  32'h0,         32'h0,         148};
    vecs[5] = '{2'd1, 1'b1, 11'd8,    32'h0,         2'd1, 1'b0, 2'b01, 16'd1,  32'h3000_0014, 32'h5555_555D, 32};
    vecs[6] = '{2'd2, 1'b0, 11'd10,   32'h0,         2'd2, 1'b0, 2'b01, 16'd10, 32'h3000_0000, 32'h0000_0008, 20};
    vecs[7] = '{2'd1, 1'b0, 11'd20,   32'h0,         2'd0, 1'b1, 2'b00, 16'd0,  32'h0,         32'h0,         40};
    vecs[8] = '{2'd0, 1'b1, 11'd1024, 32'h0,         2'd0, 1'b0, 2'b00, 16'd0,  32'h0,         32'h0,         4096};

    rst = 1'b1; start = 1'b0; mode = '0; invert = 1'b0; words = '0; seed = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // words = 0 finishes one cycle after the start edge
    pulse_start(2'd0, 1'b0, 11'd0, 32'h0);
    check("w0_busy", 64'(busy), 1);
    check("w0_done_early", 64'(done), 0);
    @(negedge clk);
    check("w0_done", 64'(done), 1);
    check("w0_busy_end", 64'(busy), 0);
    check("w0_status", 64'(status), 0);
    check("w0_cp", 64'(cp), 64'b101011);
    check("w0_cyc", 64'(wb.wbm_cyc_o), 0);

    // Silent slave: cyc must stay up exactly TIMEOUT cycles
    sb_q.delete();
    ack_en = 1'b0;
    pulse_start(2'd0, 1'b0, 11'd4, 32'h0);
    cnt = 0;
    k   = 0;
    while (k < 1000) begin
      @(negedge clk);
      k++;
      if (wb.wbm_cyc_o) begin
        if (cnt == 0) check("tmo_first_adr", 64'(wb.wbm_adr_o), 64'(BASE));
        cnt++;
      end else if (cnt > 0) begin
        break;
      end
    end
    check("tmo_cyc_cycles", 64'(cnt), 255);
    check("tmo_stb", 64'(wb.wbm_stb_o), 0);
    check("tmo_done", 64'(done), 1);
    check("tmo_status", 64'(status), 64'b10);
    check("tmo_errcnt", 64'(err_count), 0);
    check("tmo_cp", 64'(cp), 64'b101011);
    ack_en = 1'b1;

    // Reset while the read of word 7 is outstanding
    sb_q.delete();
    push_expected(2'd0, 1'b0, 16, 32'h0);
    pulse_start(2'd0, 1'b0, 11'd16, 32'h0);
    k = 0;
    while (k < 2000) begin
      @(posedge clk);
      #1;
      k++;
      if (wb.wbm_cyc_o && wb.wbm_stb_o && !wb.wbm_we_o && wb.wbm_adr_o == 32'h3000_001C) break;
    end
    check("rdw7_found", 64'(k < 2000), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    run_vec(vecs[0], 9);

    // Reset beats a simultaneous start
    @(negedge clk);
    mode = 2'd0; words = 11'd4; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("rst_start_busy", 64'(busy), 0);
    check("rst_start_cp", 64'(cp), 0);
    check("rst_start_done", 64'(done), 0);
    @(negedge clk);
    check("rst_start_idle", 64'(wb.wbm_cyc_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_ram_bist.md
Name: wb_ram_bist

Overview:
- Parametrised Wishbone-master memory self-test engine that exercises a Wishbone SRAM (OpenRAM macro wrapper) from inside the user project.
- Writes a programmable pattern over a word range, reads it back, counts mismatches, optionally repeats with inverted data.
- Reports progress on checkpoint/status codes intended for mprj_io, so a testbench only needs to watch pins.
- Successor to the firmware-driven RAM IO test: width, depth, pattern mode and inverse pass are configurable, with ack timeout detection.

Parameters:
- DATA_WIDTH, 32: Wishbone data width; multiple of 8.
- ADDR_WIDTH, 10: word-address bits of the tested range; maximum range is 2^ADDR_WIDTH words.
- BASE_ADDR, 32'h3000_0000: byte address of word 0.
- TIMEOUT, 255: maximum cycles to wait for ack; range 1..65535.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle start pulse; ignored while busy_o=1.
- mode_i  in  2  pattern: 0 = address-as-data, 1 = checkerboard, 2 = constant seed, 3 = LFSR.
- invert_i  in  1  adds a second write/read pass with inverted pattern.
- words_i  in  ADDR_WIDTH+1  number of words to test; 0 = nothing.
- seed_i  in  DATA_WIDTH  seed for modes 2 and 3.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls.
- wbm_sel_o  out  DATA_WIDTH/8  byte selects; all ones whenever stb=1.
- wbm_adr_o  out  32  BASE_ADDR + 4*index.
- wbm_dat_o  out  DATA_WIDTH  write data.
- wbm_dat_i  in  DATA_WIDTH  read data.
- wbm_ack_i  in  1  slave ack.
- busy_o, done_o  out  1 each  run active; result valid (sticky until next start).
- checkpoint_o  out  6  6'b000000 idle, 6'b101010 running, 6'b101011 done.
- status_o  out  2  2'b00 pass, 2'b01 mismatch, 2'b10 timeout.
- err_count_o  out  16  mismatch count; saturates at 16'hFFFF.
- err_addr_o  out  32  byte address of first mismatch.
- err_data_o  out  DATA_WIDTH  data read at first mismatch.

Behaviour:
- Reset: all outputs 0; FSM in IDLE. Reset mid-run drops cyc/stb at the same edge.
- FSM states: IDLE -> WR_REQ -> WR_WAIT -> (next index) ... -> RD_REQ -> RD_WAIT -> ... -> [second pass if invert_i] -> DONE -> IDLE (on next start).
- Start handling:
  - start_i in IDLE or DONE latches mode_i, invert_i, words_i and seed_i.
  - Clears done_o, the error registers and status; sets busy_o and checkpoint 101010 on the next edge.
  - words_i=0: DONE after one cycle, status 00.
- Bus transactions:
  - Classic single access. cyc, stb, we and adr are asserted together and held until ack is sampled high.
  - The edge that samples ack deasserts cyc and stb.
  - At least one idle cycle separates transactions; no bursts, no pipelining.
- Phase order: write indices 0..words-1, then read indices 0..words-1. If invert_i, repeat both phases with pattern XOR all-ones.
- Patterns:
  - Mode 0: index zero-extended.
  - Mode 1: index even -> 0x55 repeated, odd -> 0xAA repeated.
  - Mode 2: seed.
  - Mode 3: Galois LFSR, one step per word. For 32 bits the taps are 0x8020_0003. Seed 0 is replaced by 1. The LFSR is reloaded from the seed at the start of every phase, so read data regenerates the written sequence.
- Checking:
  - Read data is compared in the ack cycle.
  - On mismatch, err_count increments (saturating). On the first mismatch only, err_addr and err_data are captured.
- Timeout:
  - A counter reloads at each request. If ack is still absent after TIMEOUT cycles, the engine drops cyc/stb, aborts to DONE and sets status 10. Timeout takes priority over mismatch.
- DONE: busy=0, done=1, checkpoint 101011. status = 10 if timeout, else 01 if err_count≠0, else 00.
- Simultaneous start_i and wb_rst_i: reset wins.
- Ack arriving while stb=0 is ignored.

Test Plan:
- Ideal 1-cycle-ack RAM model, mode 0, words=16, invert 0 -> 16 writes then 16 reads; data at 0x3000_0000+4i equals i; status 00, err_count 0, checkpoint 101011.
- Mode 1, invert 1, words=4 -> write/read sequence 55,AA,55,AA then AA,55,AA,55 (byte-repeated); 16 transactions; pass.
- Mode 3, seed 0, words=1024 -> LFSR starts at 1; all reads match; exactly 2048 acks; status 00.
- Model with a stuck bit 3 at word 5, mode 2, seed 0 -> err_count 1, err_addr 0x3000_0014, err_data 0x0000_0008, status 01.
- Slave never acks, TIMEOUT=255 -> cyc drops 255 cycles after the first request; status 10; done 1; err_count 0.
- Reset asserted during RD_WAIT of word 7 -> cyc/stb 0 at the next edge; all outputs 0. A new start then runs cleanly to pass.
